// File: rtl/sipo_deser32_pkg.sv
// sipo_pkg: shared constants for the sipo_deser32 serial receiver.
// State encodings are plain localparam constants so older tools and
// netlist-level scripts can match them by value.
// Optional feature macro: SIPO_PARITY_CHECK_EN (adds the S_PARITY state).
package sipo_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

endpackage

// File: rtl/sipo_deser32_if.sv
// sipo_deser32_if: frame handshake and parallel result bundle for the
// serial receiver. The master drives start/in/en; the slave (receiver)
// returns the word, the valid pulse and its status.
// Optional feature macro: SIPO_PARITY_CHECK_EN (adds perr).
interface sipo_deser32_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             start;
    logic             in;
    logic             en;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             busy;
    logic [CNT_W-1:0] count;
`ifdef SIPO_PARITY_CHECK_EN
    logic             perr;

    modport master (output start, in, en, input out, valid, busy, count, perr);
    modport slave  (input start, in, en, output out, valid, busy, count, perr);
`else
    modport master (output start, in, en, input out, valid, busy, count);
    modport slave  (input start, in, en, output out, valid, busy, count);
`endif

endinterface

// File: rtl/sipo_bit_counter.sv
// sipo_bit_counter: bit position counter for the serial receiver.
// Clear wins over increment; last flags the final data bit position.
module sipo_bit_counter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    // Count accepted bits; cleared on frame arm and on frame completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + 1'b1;
    end

    assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/sipo_deser32.sv
// sipo_deser32: serial-in, parallel-out receiver, MSB first.
// Optional feature macro: SIPO_PARITY_CHECK_EN (even-parity bit after data,
// result reported on perr).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; en ignored
// S_SHIFT  | collecting data bits on en=1; start restarts the frame
// S_PARITY | waiting for the parity bit on en=1 (parity build only)
module sipo_deser32
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    sipo_deser32_if.slave bus
);

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             take_bit;
    logic             final_bit;

    // start always has priority, so a bit offered in the start cycle is dropped
    assign take_bit  = (state == S_SHIFT) && bus.en && !bus.start;
    assign final_bit = take_bit && last;
    assign shreg_nxt = {shreg[WIDTH-2:0], bus.in};

    sipo_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.start || final_bit),
        .inc   (take_bit),
        .count (count),
        .last  (last)
    );

`ifdef SIPO_PARITY_CHECK_EN
    logic take_par;
    assign take_par = (state == S_PARITY) && bus.en && !bus.start;

    // Frame sequencing: arm/restart, data bits, then the parity bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else if (bus.start)
            state <= S_SHIFT;
        else if (final_bit)
            state <= S_PARITY;
        else if (take_par)
            state <= S_IDLE;
    end

    // Publish the word and parity result on the parity bit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out   <= '0;
            bus.valid <= 1'b0;
            bus.perr  <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            if (take_par) begin
                bus.out   <= shreg;
                bus.valid <= 1'b1;
                bus.perr  <= (^shreg) ^ bus.in;
            end
        end
    end
`else
    // The MSB is only shifted out; it is never needed for the result.
    logic unused_msb;
    assign unused_msb = shreg[WIDTH-1];

    // Frame sequencing: arm/restart, then data bits back to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else if (bus.start)
            state <= S_SHIFT;
        else if (final_bit)
            state <= S_IDLE;
    end

    // Publish the word on the edge that samples the final data bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out   <= '0;
            bus.valid <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            if (final_bit) begin
                bus.out   <= shreg_nxt;
                bus.valid <= 1'b1;
            end
        end
    end
`endif

    // Shift register: cleared on arm so a restart never mixes in stale bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shreg <= '0;
        else if (bus.start)
            shreg <= '0;
        else if (take_bit)
            shreg <= shreg_nxt;
    end

    assign bus.busy  = (state != S_IDLE);
    assign bus.count = count;

endmodule

// File: tb/tb_sipo_deser32.sv
// tb_sipo_deser32: directed-vector bench for sipo_deser32.
// Optional feature macro: SIPO_PARITY_CHECK_EN (adds parity bit and perr checks).
module tb_sipo_deser32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sipo_deser32_if #(.WIDTH(32), .CNT_W(6)) bus ();

    sipo_deser32 #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef SIPO_PARITY_CHECK_EN
    localparam int FRAME_PERIOD = 34;
`else
    localparam int FRAME_PERIOD = 33;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int valid_seen = 0;
    int last_valid_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.valid === 1'b1) begin
            valid_seen++;
            last_valid_cyc = cyc;
        end
    endtask

    task automatic arm;
        bus.start = 1'b1;
        bus.en    = 1'b1;   // must be ignored in the start cycle
        bus.in    = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.en    = 1'b0;
    endtask

    task automatic shift_bits(input logic [31:0] w, input int nbits, input bit gap);
        for (int k = 1; k <= nbits; k++) begin
            bus.in = w[32-k];
            bus.en = 1'b1;
            tick;
            if (gap && (k % 4 == 0) && (k < 32)) begin
                bus.en = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    tick;
                    check($sformatf("gap_count_b%0d", k), {26'd0, bus.count}, 32'(k));
                end
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w, input bit gap, input logic par, input string tag);
        int v0;
        arm;
        check({tag, "_armed_busy"}, {31'd0, bus.busy}, 32'd1);
        check({tag, "_armed_count"}, {26'd0, bus.count}, 32'd0);
        v0 = valid_seen;
        shift_bits(w, 32, gap);
`ifdef SIPO_PARITY_CHECK_EN
        check({tag, "_par_wait_valid"}, {31'd0, bus.valid}, 32'd0);
        check({tag, "_par_wait_busy"}, {31'd0, bus.busy}, 32'd1);
        bus.in = par;
        bus.en = 1'b1;
        tick;
        bus.en = 1'b0;
        check({tag, "_perr"}, {31'd0, bus.perr}, {31'd0, (^w) ^ par});
`else
        if (par !== 1'bx) begin end
`endif
        check({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
        check({tag, "_out"}, bus.out, w);
        check({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_count_done"}, {26'd0, bus.count}, 32'd0);
        check({tag, "_valid_once"}, 32'(valid_seen - v0), 32'd1);
    endtask

    initial begin
        int v0;
        int c1;
        bus.start = 1'b0;
        bus.in    = 1'b0;
        bus.en    = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check("rst_out", bus.out, 32'd0);
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_count", {26'd0, bus.count}, 32'd0);
        rst = 1'b0;

        // basic frame, then the pulse must drop after one cycle
        send_frame(32'hA5A50F3C, 1'b0, 1'b0, "basic");
        tick;
        check("basic_valid_width", {31'd0, bus.valid}, 32'd0);
        check("basic_out_hold", bus.out, 32'hA5A50F3C);

        // gapped enable
        send_frame(32'h80000001, 1'b1, 1'b0, "gapped");

        // abort after 10 bits, restart with a full frame
        arm;
        v0 = valid_seen;
        shift_bits(32'hFFFFFFFF, 10, 1'b0);
        check("abort_count", {26'd0, bus.count}, 32'd10);
        check("abort_busy", {31'd0, bus.busy}, 32'd1);
        send_frame(32'h12345678, 1'b0, 1'b1, "restart");
        check("abort_no_extra_valid", 32'(valid_seen - v0), 32'd1);

        // asynchronous reset mid-frame
        arm;
        shift_bits(32'h0F0F0F0F, 20, 1'b0);
        check("midrst_count_pre", {26'd0, bus.count}, 32'd20);
        #3 rst = 1'b1;
        #1;
        check("midrst_out", bus.out, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_count", {26'd0, bus.count}, 32'd0);
        #2 rst = 1'b0;
        send_frame(32'hDEADBEEF, 1'b0, 1'b0, "after_rst");

        // back-to-back frames, start on the cycle valid is high
        send_frame(32'h00000000, 1'b0, 1'b0, "b2b_zero");
        c1 = last_valid_cyc;
        send_frame(32'hFFFFFFFF, 1'b0, 1'b0, "b2b_ones");
        check("b2b_period", 32'(last_valid_cyc - c1), 32'(FRAME_PERIOD));

        // en in IDLE is ignored
        bus.en = 1'b1;
        bus.in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("idle_en_busy", {31'd0, bus.busy}, 32'd0);
            check("idle_en_count", {26'd0, bus.count}, 32'd0);
            check("idle_en_valid", {31'd0, bus.valid}, 32'd0);
        end
        check("idle_en_out", bus.out, 32'hFFFFFFFF);
        bus.en = 1'b0;

`ifdef SIPO_PARITY_CHECK_EN
        send_frame(32'h00000007, 1'b0, 1'b1, "par_good");
        check("par_good_perr", {31'd0, bus.perr}, 32'd0);
        send_frame(32'h00000007, 1'b0, 1'b0, "par_bad");
        check("par_bad_perr", {31'd0, bus.perr}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
